// File: rtl/mem_stage_pkg.sv
// Shared encodings for the non-blocking memory stage: load-op fields and lane-index sizing.
package mem_stage_pkg;
    localparam logic [1:0] LOAD_SZ_B = 2'd0;
    localparam logic [1:0] LOAD_SZ_H = 2'd1;
    localparam logic [1:0] LOAD_SZ_W = 2'd2;
    localparam logic [1:0] LOAD_SZ_D = 2'd3;
    localparam int         LOAD_SIGN = 2;
    localparam int         LOAD_OP_W = 3;

    // Number of address bits that pick a byte lane inside one data word.
    function automatic int lane_idx_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction
endpackage

// File: rtl/mem_stage_nb_if.sv
// EX/SRAM/WB-facing signal bundle of mem_stage_nb; slave is the stage, master the surroundings.
interface mem_stage_nb_if
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 160
);
    logic                          es_to_ms_valid;
    logic                          ms_allowin;
    logic                          es_need_mem;
    logic                          es_is_load;
    logic [LOAD_OP_W-1:0]          es_load_op;
    logic [DATA_W-1:0]             es_alu_result;
    logic [PAYLOAD_W-1:0]          es_payload;
    logic                          data_sram_data_ok;
    logic [DATA_W-1:0]             data_sram_rdata;
    logic                          ms_to_ws_valid;
    logic                          ws_allowin;
    logic [PAYLOAD_W+DATA_W-1:0]   ms_to_ws_bus;
    logic                          flush;
    logic                          ms_resp_err;

    modport slave (
        input  es_to_ms_valid, es_need_mem, es_is_load, es_load_op, es_alu_result, es_payload,
        input  data_sram_data_ok, data_sram_rdata, ws_allowin, flush,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_resp_err
    );

    modport master (
        output es_to_ms_valid, es_need_mem, es_is_load, es_load_op, es_alu_result, es_payload,
        output data_sram_data_ok, data_sram_rdata, ws_allowin, flush,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_resp_err
    );
endinterface

// File: rtl/ms_load_align.sv
// Load data lane select and sign/zero extension; purely combinational.
module ms_load_align
    import mem_stage_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = lane_idx_w(DATA_W)
) (
    input  logic [DATA_W-1:0]    rdata,
    input  logic [OFF_W-1:0]     offset,
    input  logic [LOAD_OP_W-1:0] load_op,
    output logic [DATA_W-1:0]    result
);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [6:0]        width;
    logic              sign_bit;

    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        mask     = '1;
        sign_bit = 1'b0;
        case (load_op[1:0])
            LOAD_SZ_B: width = 7'd8;
            LOAD_SZ_H: width = 7'd16;
            LOAD_SZ_W: width = 7'd32;
            LOAD_SZ_D: width = 7'd64;
            default:   width = 7'd64;
        endcase
        if (int'(width) >= DATA_W) begin
            result = shifted;
        end else begin
            mask     = ~({DATA_W{1'b1}} << width);
            // mask ^ (mask >> 1) isolates the top bit of the loaded field
            sign_bit = load_op[LOAD_SIGN] & (|(shifted & (mask ^ (mask >> 1))));
            result   = (shifted & mask) | ({DATA_W{sign_bit}} & ~mask);
        end
    end
endmodule

// File: rtl/mem_stage_nb.sv
// Non-blocking MEM stage: DEPTH-entry in-order queue between EX and WB with response drain on flush.
// Optional MS_DATA_BYPASS_EN: forward a head-targeted response straight to WB in its arrival cycle.
module mem_stage_nb
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 160
) (
    input  logic           clk,
    input  logic           reset,
    mem_stage_nb_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int DC_W  = $clog2(2 * DEPTH + 2);
    localparam int OFF_W = lane_idx_w(DATA_W);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic                 need_mem;
        logic                 is_load;
        logic [LOAD_OP_W-1:0] load_op;
        logic [DATA_W-1:0]    alu_result;
    } ms_req_t;

    ms_req_t           ent_req   [DEPTH];
    logic [DATA_W-1:0] ent_rdata [DEPTH];
    logic [DEPTH-1:0]  ent_vld, ent_dv;

    logic [IDX_W-1:0]  head, tail, fill_idx;
    logic [CNT_W-1:0]  count;
    logic [DC_W-1:0]   discard_cnt, awaiting_cnt;
    logic              resp_err, fill_found;

    logic              allowin, push, pop, resp_live, fill_hit, fill_wr, dc_dec;
    logic              head_rdy, out_valid;
    logic [DATA_W-1:0] head_aligned, out_result;

    // Oldest awaiting entry and number of awaiting entries, scanned from head.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx          = head;
        fill_found   = 1'b0;
        fill_idx     = head;
        awaiting_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + IDX_W'(i);
            if (ent_vld[idx] && ent_req[idx].need_mem && !ent_dv[idx]) begin
                awaiting_cnt = awaiting_cnt + DC_W'(1);
                if (!fill_found) begin
                    fill_found = 1'b1;
                    fill_idx   = idx;
                end
            end
        end
    end

    assign allowin   = count < CNT_W'(DEPTH);
    assign push      = bus.es_to_ms_valid & allowin & ~bus.flush;
    assign resp_live = bus.data_sram_data_ok & (discard_cnt == '0);
    assign dc_dec    = bus.data_sram_data_ok & (discard_cnt != '0);
    assign fill_hit  = resp_live & fill_found;
    assign head_rdy  = ent_vld[head] & ent_dv[head];

    ms_load_align #(.DATA_W(DATA_W)) u_align_head (
        .rdata   (ent_rdata[head]),
        .offset  (ent_req[head].alu_result[OFF_W-1:0]),
        .load_op (ent_req[head].load_op),
        .result  (head_aligned)
    );

`ifdef MS_DATA_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_aligned;

    ms_load_align #(.DATA_W(DATA_W)) u_align_byp (
        .rdata   (bus.data_sram_rdata),
        .offset  (ent_req[head].alu_result[OFF_W-1:0]),
        .load_op (ent_req[head].load_op),
        .result  (byp_aligned)
    );

    // The fill target never has data_valid set, so byp_hit and head_rdy are exclusive.
    assign byp_hit    = fill_hit & (fill_idx == head);
    assign out_valid  = head_rdy | byp_hit;
    assign out_result = !ent_req[head].is_load ? ent_req[head].alu_result
                      : byp_hit                ? byp_aligned : head_aligned;
    assign fill_wr    = fill_hit & ~(byp_hit & bus.ws_allowin);
`else
    assign out_valid  = head_rdy;
    assign out_result = ent_req[head].is_load ? head_aligned : ent_req[head].alu_result;
    assign fill_wr    = fill_hit;
`endif

    assign pop = out_valid & bus.ws_allowin & ~bus.flush;

    assign bus.ms_allowin     = allowin;
    assign bus.ms_to_ws_valid = out_valid & ~bus.flush;
    assign bus.ms_to_ws_bus   = {ent_req[head].payload, out_result};
    assign bus.ms_resp_err    = resp_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            discard_cnt <= '0;
            resp_err    <= 1'b0;
            ent_vld     <= '0;
            ent_dv      <= '0;
        end else begin
            if (resp_live && !fill_found)
                resp_err <= 1'b1;
            if (bus.flush) begin
                // A same-cycle live response is charged to the old awaiting set.
                discard_cnt <= discard_cnt - DC_W'(dc_dec) + awaiting_cnt
                             + DC_W'(bus.es_to_ms_valid & bus.es_need_mem) - DC_W'(fill_hit);
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                ent_vld <= '0;
            end else begin
                if (dc_dec)
                    discard_cnt <= discard_cnt - DC_W'(1);
                if (push) begin
                    ent_vld[tail] <= 1'b1;
                    ent_dv[tail]  <= ~bus.es_need_mem;
                    tail          <= tail + IDX_W'(1);
                end
                if (fill_wr)
                    ent_dv[fill_idx] <= 1'b1;
                if (pop) begin
                    ent_vld[head] <= 1'b0;
                    head          <= head + IDX_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            ent_req[tail] <= '{payload:    bus.es_payload,
                               need_mem:   bus.es_need_mem,
                               is_load:    bus.es_is_load,
                               load_op:    bus.es_load_op,
                               alu_result: bus.es_alu_result};
        if (fill_wr && !bus.flush)
            ent_rdata[fill_idx] <= bus.data_sram_rdata;
    end
endmodule
